// File: rtl/chunk_seq_adder_pkg.sv
// chunk_seq_adder_pkg: shared constants and FSM state encoding for chunk_seq_adder.
// Rev 1.0
`default_nettype none

package chunk_seq_adder_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_C = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

endpackage

`default_nettype wire

// File: rtl/chunk_seq_adder_if.sv
// chunk_seq_adder_if: operand/result handshake bundle; ovf present only with CHUNK_SEQ_ADDER_OVF_EN.
// Rev 1.0
`default_nettype none

interface chunk_seq_adder_if #(
  parameter int N = chunk_seq_adder_pkg::DEF_N
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef CHUNK_SEQ_ADDER_OVF_EN
  logic         ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef CHUNK_SEQ_ADDER_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef CHUNK_SEQ_ADDER_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

`default_nettype wire

// File: rtl/chunk_seq_adder_fa.sv
// chunk_fa: combinational W-bit ripple full adder, also exposing the carry into its MSB.
// Rev 1.0
`default_nettype none

module chunk_fa #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

`default_nettype wire

// File: rtl/chunk_seq_adder.sv
// chunk_seq_adder: adds a+b+cin over N/C cycles, one C-bit chunk per cycle, with valid/ready handshakes.
// Rev 1.0 -- optional signed-overflow output enabled by CHUNK_SEQ_ADDER_OVF_EN.
`default_nettype none

module chunk_seq_adder
  import chunk_seq_adder_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int C = DEF_C
) (
  input  logic             clk,
  input  logic             rst,
  chunk_seq_adder_if.slave bus
);

  localparam int NCH = (C > 0) ? (N / C) : 1;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (C < 1) begin : g_bad_c
    $error("chunk_seq_adder: C must be at least 1");
  end else if ((N % C) != 0) begin : g_bad_n
    $error("chunk_seq_adder: N must be an integer multiple of C");
  end

  logic [1:0]    state;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic          carry;
  logic [KW-1:0] k;
  logic [N-1:0]  sum_r;
  logic          cout_r;
  int            idx;
  logic          last;
  logic [C-1:0]  fa_sum;
  logic          fa_cout;
  logic          fa_cmsb;

  assign idx  = int'(k) * C;
  assign last = (k == KW'(NCH - 1));

  chunk_fa #(.W(C)) u_fa (
    .a     (a_r[idx +: C]),
    .b     (b_r[idx +: C]),
    .cin   (carry),
    .sum   (fa_sum),
    .cout  (fa_cout),
    .c_msb (fa_cmsb)
  );

`ifdef CHUNK_SEQ_ADDER_OVF_EN
  logic ovf_r;
  assign bus.ovf = ovf_r;
`else
  logic unused_cmsb;
  assign unused_cmsb = fa_cmsb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      carry  <= 1'b0;
      k      <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
`ifdef CHUNK_SEQ_ADDER_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            carry <= bus.cin;
            k     <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_r[idx +: C] <= fa_sum;
          carry           <= fa_cout;
          if (last) begin
            // The final chunk's carry-out is the carry out of bit N-1.
            k      <= '0;
            cout_r <= fa_cout;
`ifdef CHUNK_SEQ_ADDER_OVF_EN
            ovf_r  <= fa_cmsb ^ fa_cout;
`endif
            state  <= ST_DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE) && !rst;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state == ST_RUN) || (state == ST_DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;

endmodule

`default_nettype wire
